// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants for the 1024x768@60 (65 MHz) VGA mode,
// used by both the timing generator and the receive-side checker, plus the
// receiver FSM state type and a small window helper.
package vga_timing_pkg;

  localparam int   H_TOTAL     = 1344;  // pixel clocks per line
  localparam int   H_SYNC      = 136;   // hsync pulse width
  localparam int   H_BP        = 296;   // first visible hc
  localparam int   H_FP        = 1320;  // first non-visible hc after active
  localparam int   V_TOTAL     = 806;   // lines per frame
  localparam int   V_SYNC      = 6;     // vsync pulse width in lines
  localparam int   V_BP        = 35;    // first visible vc
  localparam int   V_FP        = 803;   // first non-visible vc
  localparam logic SYNC_POL    = 1'b0;  // active level of both syncs
  localparam int   LOCK_FRAMES = 2;     // good frames needed for lock
  localparam int   CW          = 11;    // hc/vc width

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  // True when lo <= v < hi.
  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchroniser followed by a leading-edge register.
// lead pulses for one cycle when the synchronised input moves to the POL
// level; the pulse appears three clocks after the pin changes.
// Ports:
//   clk  - pixel clock
//   clr  - synchronous active-high reset (flops return to the idle level)
//   sig  - raw sync input
//   lead - one-cycle leading-edge flag
module sync_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic sig,
  output logic lead
);

  logic sig_p0, sig_p1, sig_p2;

  always_ff @(posedge clk) begin
    if (clr) begin
      // Idle level, so a sync already inactive at release gives no edge.
      sig_p0 <= ~POL;
      sig_p1 <= ~POL;
      sig_p2 <= ~POL;
      lead   <= 1'b0;
    end else begin
      // p0/p1: synchroniser, p2: previous synchronised value
      sig_p0 <= sig;
      sig_p1 <= sig_p0;
      sig_p2 <= sig_p1;
      lead   <= (sig_p1 == POL) && (sig_p2 != POL);
    end
  end

endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side VGA timing checker. Reconstructs hc/vc and
// the vidon window from incoming hsync/vsync, verifies line and frame
// lengths against the configured mode and reports lock.
// Ports:
//   clk, clr           - pixel clock, synchronous active-high reset
//   hsync, vsync       - syncs under test
//   hc, vc             - reconstructed counters (hc saturates = loss of signal)
//   vidon              - visible window while locked, aligned with hc/vc
//   locked             - timing matches for LOCK_FRAMES consecutive frames
//   timing_err         - one-cycle pulse on a mismatch while locked
//   frame_start        - one-cycle pulse per vsync edge in MEASURE/LOCKED
//   frame_cnt, err_cnt - only when VGA_RX_STATS_EN is defined
module vga_timing_rx #(
  parameter int   H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BP        = vga_timing_pkg::H_BP,
  parameter int   H_FP        = vga_timing_pkg::H_FP,
  parameter int   V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BP        = vga_timing_pkg::V_BP,
  parameter int   V_FP        = vga_timing_pkg::V_FP,
  parameter logic SYNC_POL    = vga_timing_pkg::SYNC_POL,
  parameter int   LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES,
  parameter int   CW          = vga_timing_pkg::CW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          hsync,
  input  logic          vsync,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          vidon,
  output logic          locked,
  output logic          timing_err,
  output logic          frame_start
`ifdef VGA_RX_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt
`endif
);

  import vga_timing_pkg::*;

  localparam int            GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [GW-1:0] G_LOCK  = GW'(LOCK_FRAMES);

  logic h_lead, v_lead;

  sync_edge_det #(.POL(SYNC_POL)) u_hs (
    .clk  (clk),
    .clr  (clr),
    .sig  (hsync),
    .lead (h_lead)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vs (
    .clk  (clk),
    .clr  (clr),
    .sig  (vsync),
    .lead (v_lead)
  );

  rx_state_t     state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [CW-1:0] hc_nxt, vc_nxt;
  logic          v_pend, v_pend_nxt;   // vsync seen, waiting for next hsync
  logic          frame_bad, frame_bad_nxt;
  logic          line_bad, frame_good, sat;
  logic          err_nxt, fs_nxt, locked_nxt, vidon_nxt;

  // Edge stage -> counter/FSM stage
  always_comb begin
    hc_nxt        = hc;
    vc_nxt        = vc;
    v_pend_nxt    = v_pend;
    frame_bad_nxt = frame_bad;
    state_nxt     = state;
    good_nxt      = good_cnt;
    err_nxt       = 1'b0;
    fs_nxt        = 1'b0;

    // Checks use the pre-clear counts; a bad line ending on the same edge
    // as vsync still belongs to the frame being judged.
    line_bad   = h_lead && (hc != H_LAST);
    frame_good = (vc == V_LAST) && !frame_bad && !line_bad;

    if (h_lead)             hc_nxt = '0;
    else if (hc != CNT_MAX) hc_nxt = hc + 1'b1;

    if (h_lead) begin
      if (v_lead || v_pend) vc_nxt = '0;
      else if (vc != CNT_MAX) vc_nxt = vc + 1'b1;
    end

    if (h_lead)      v_pend_nxt = 1'b0;
    else if (v_lead) v_pend_nxt = 1'b1;

    if (v_lead)        frame_bad_nxt = 1'b0;
    else if (line_bad) frame_bad_nxt = 1'b1;

    case (state)
      SEARCH: begin
        if (v_lead) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          fs_nxt = 1'b1;
          if (frame_good) begin
            good_nxt = good_cnt + 1'b1;
            if (good_cnt + 1'b1 == G_LOCK) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        fs_nxt = v_lead;
        if (line_bad || (v_lead && !frame_good)) begin
          err_nxt   = 1'b1;
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
    endcase

    // A saturated hc means hsync has gone away entirely.
    sat = (hc_nxt == CNT_MAX);
    if (sat) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
    end

    locked_nxt = (state_nxt == LOCKED);
    vidon_nxt  = locked_nxt &&
                 in_span(int'(hc_nxt), H_BP, H_FP) &&
                 in_span(int'(vc_nxt), V_BP, V_FP);
  end

  // Counter/FSM stage -> registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= SEARCH;
      good_cnt    <= '0;
      hc          <= '0;
      vc          <= '0;
      v_pend      <= 1'b0;
      frame_bad   <= 1'b0;
      vidon       <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      v_pend      <= v_pend_nxt;
      frame_bad   <= frame_bad_nxt;
      vidon       <= vidon_nxt;
      locked      <= locked_nxt;
      timing_err  <= err_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef VGA_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (fs_nxt)                   frame_cnt <= frame_cnt + 16'd1;
      if (err_nxt && err_cnt != '1) err_cnt   <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
